// File: rtl/compositor_pkg.sv
// rtl/compositor_pkg.sv - shared types and sizing constants for the layer compositor
package compositor_pkg;

    typedef logic [15:0] rgb565_t;

    localparam int PIXELS                = 6144;
    localparam int IDX_W                 = 13;
    localparam int FLASH_FRAMES_DEFAULT  = 8;
    localparam int CNT_W                 = $clog2(FLASH_FRAMES_DEFAULT + 1);

    function automatic int flash_cnt_w(input int frames);
        return $clog2(frames + 1);
    endfunction

endpackage

// File: rtl/compositor_flash_ctr.sv
// rtl/compositor_flash_ctr.sv - per-layer hit-flash frame counter
// A request always reloads the count, even on a frame_begin cycle.
module compositor_flash_ctr
    import compositor_pkg::*;
#(
    parameter int FLASH_FRAMES = FLASH_FRAMES_DEFAULT,
    parameter int CNT_W_P      = CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flash_req,
    input  logic frame_begin,
    output logic active
);

    logic [CNT_W_P-1:0] cnt_q;
    logic [CNT_W_P-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flash_req) begin
            cnt_d = CNT_W_P'(FLASH_FRAMES);
        end else if (frame_begin && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W_P'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active = (cnt_q != '0);

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - N-layer RGB565 priority compositor with per-frame overlap capture
// Hit-flash counters are built only when COMPOSITOR_FLASH_EN is defined.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int      N_LAYERS     = 4,
    parameter rgb565_t TRANSPARENT  = 16'h0000,
    parameter rgb565_t BG_COLOUR    = 16'h0000,
    parameter int      FLASH_FRAMES = 8,
    parameter rgb565_t FLASH_COLOUR = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     frame_begin,
    input  logic                     in_valid,
    input  logic [IDX_W-1:0]         pixel_index,
    input  logic [16*N_LAYERS-1:0]   layer_colour,
    input  logic [N_LAYERS-1:0]      layer_en,
    input  logic [N_LAYERS-1:0]      flash_req,
    output logic                     out_valid,
    output logic [IDX_W-1:0]         out_index,
    output logic [15:0]              oled_colour,
    output logic [N_LAYERS-1:0]      overlap_out
);

    logic                   s1_valid_q;
    logic [IDX_W-1:0]       s1_index_q;
    logic [16*N_LAYERS-1:0] s1_colour_q;
    logic [N_LAYERS-1:0]    active_en_q;
    logic [N_LAYERS-1:0]    acc_q;
    logic [N_LAYERS-1:0]    acc_d;
    logic [N_LAYERS-1:0]    overlap_q;
    logic                   out_valid_q;
    logic [IDX_W-1:0]       out_index_q;
    rgb565_t                oled_colour_q;

    logic [N_LAYERS-1:0]    opaque;
    logic [N_LAYERS-1:0]    hit;
    logic [N_LAYERS-1:0]    flash_act;
    rgb565_t                sel_colour;

`ifdef COMPOSITOR_FLASH_EN
    localparam int FLASH_CNT_W = flash_cnt_w(FLASH_FRAMES);

    for (genvar g = 0; g < N_LAYERS; g++) begin : g_flash
        compositor_flash_ctr #(
            .FLASH_FRAMES (FLASH_FRAMES),
            .CNT_W_P      (FLASH_CNT_W)
        ) u_flash_ctr (
            .clk         (clk),
            .reset_n     (reset_n),
            .flash_req   (flash_req[g]),
            .frame_begin (frame_begin),
            .active      (flash_act[g])
        );
    end
`else
    logic unused_flash;
    assign unused_flash = ^{flash_req, FLASH_FRAMES[7:0]};
    assign flash_act    = '0;
`endif

    // Descending scan so the lowest-index opaque layer is the last (winning) assignment.
    always_comb begin
        opaque     = '0;
        hit        = '0;
        sel_colour = BG_COLOUR;
        for (int i = 0; i < N_LAYERS; i++) begin
            opaque[i] = active_en_q[i] && (s1_colour_q[16*i +: 16] != TRANSPARENT);
        end
        for (int i = 0; i < N_LAYERS; i++) begin
            hit[i] = opaque[i] && (|(opaque & ~(N_LAYERS'(1) << i)));
        end
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                sel_colour = flash_act[i] ? FLASH_COLOUR : s1_colour_q[16*i +: 16];
            end
        end
    end

    // A pixel sitting in S1 on the frame_begin cycle is credited to the new frame.
    always_comb begin
        acc_d = frame_begin ? '0 : acc_q;
        if (s1_valid_q) begin
            acc_d = acc_d | hit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_index_q    <= '0;
            s1_colour_q   <= '0;
            active_en_q   <= '1;
            acc_q         <= '0;
            overlap_q     <= '0;
            out_valid_q   <= 1'b0;
            out_index_q   <= '0;
            oled_colour_q <= BG_COLOUR;
        end else begin
            s1_valid_q  <= in_valid;
            s1_index_q  <= pixel_index;
            s1_colour_q <= layer_colour;
            acc_q       <= acc_d;
            out_valid_q <= s1_valid_q;
            if (frame_begin) begin
                active_en_q <= layer_en;
                overlap_q   <= acc_q;
            end
            if (s1_valid_q) begin
                out_index_q   <= s1_index_q;
                oled_colour_q <= sel_colour;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign oled_colour = oled_colour_q;
    assign overlap_out = overlap_q;

endmodule
